// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between the data-memory arbiter and its environment
//
// Groups the pipeline M-stage port, the external preload write port, the drain
// handshake, the single-port memory port and the status outputs.
//   slave  : arbiter view (takes requests, drives the memory port)
//   master : environment view (pipeline, preload source, memory model)
interface dmem_arbiter_if #(
  parameter int DPW        = 32,
  parameter int FIFO_DEPTH = 4
) ();
  // pipeline M stage
  logic                          memwriteM;
  logic                          memreadM;
  logic [DPW-1:0]                aluresultM;
  logic [DPW-1:0]                Rd2M;
  logic                          stall_mem;
  logic [DPW-1:0]                readdata_m;
  logic                          rd_valid_m;
  // external preload writes
  logic                          ext_valid;
  logic                          ext_ready;
  logic [DPW-1:0]                ext_addr;
  logic [DPW-1:0]                ext_data;
  // drain handshake
  logic                          drain_req;
  logic                          drain_done;
  // single-port memory
  logic                          mem_en;
  logic                          mem_we;
  logic [DPW-3:0]                mem_addr;
  logic [DPW-1:0]                mem_wdata;
  logic [DPW-1:0]                mem_rdata;
  // status
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          err_misaligned;

  modport slave (
    input  memwriteM, memreadM, aluresultM, Rd2M,
    input  ext_valid, ext_addr, ext_data, drain_req, mem_rdata,
    output stall_mem, readdata_m, rd_valid_m, ext_ready, drain_done,
    output mem_en, mem_we, mem_addr, mem_wdata, fifo_count, err_misaligned
  );

  modport master (
    output memwriteM, memreadM, aluresultM, Rd2M,
    output ext_valid, ext_addr, ext_data, drain_req, mem_rdata,
    input  stall_mem, readdata_m, rd_valid_m, ext_ready, drain_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, fifo_count, err_misaligned
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data-memory arbiter: pipeline priority, buffered preload writes
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave - pipeline request/stall/load data, external
//          write push (ext_valid/ext_ready), drain_req/drain_done, memory port
//          (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata), fifo_count, err_misaligned
//
// Pipeline accesses win unless the FIFO has been starved for STARVE_LIMIT
// consecutive pipeline-won cycles, in which case one FIFO entry is written and
// the pipeline is stalled for that cycle. A drain_req in RUN switches to an
// exclusive DRAIN that empties the FIFO, followed by a single DONE cycle.
module dmem_arbiter #(
  parameter int DPW          = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q;
  logic            drain_done_q;

  // Only the word address is kept; the byte offset of preload writes is dropped.
  logic [DPW-3:0]  fifo_addr_q [FIFO_DEPTH];
  logic [DPW-1:0]  fifo_data_q [FIFO_DEPTH];

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;

  logic            pipe_req;
  logic            fifo_empty;
  logic            pipe_win;
  logic            fifo_win;
  logic            ext_ready;
  logic            push;
  logic            pop;
  logic            unused_ext_addr_lo;

  assign unused_ext_addr_lo = ^bus.ext_addr[1:0];

  always_comb begin
    pipe_req   = bus.memwriteM || bus.memreadM;
    fifo_empty = (count_q == '0);
    pipe_win   = 1'b0;
    fifo_win   = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          pipe_win = pipe_req && (starve_q < STARVE_MAX);
          fifo_win = !pipe_win && !fifo_empty;
        end
        DRAIN:   fifo_win = !fifo_empty;
        default: ;
      endcase
    end

    // A full FIFO never accepts, even when the head is popped this cycle.
    ext_ready = !rst && (state_q == RUN) && (count_q != FULL_CNT);
    push      = bus.ext_valid && ext_ready;
    pop       = fifo_win;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Counts pipeline wins that left a waiting entry behind.
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (pipe_win && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end

    err_d      = err_q || (pipe_win && (bus.aluresultM[1:0] != 2'b00));
    rd_valid_d = pipe_win && !bus.memwriteM;
  end

  assign bus.ext_ready      = ext_ready;
  assign bus.stall_mem      = !rst && ((state_q != RUN) || (fifo_win && pipe_req));
  assign bus.mem_en         = pipe_win || fifo_win;
  assign bus.mem_we         = fifo_win || (pipe_win && bus.memwriteM);
  assign bus.mem_addr       = fifo_win ? fifo_addr_q[rd_ptr_q] : bus.aluresultM[DPW-1:2];
  assign bus.mem_wdata      = fifo_win ? fifo_data_q[rd_ptr_q] : bus.Rd2M;
  assign bus.readdata_m     = bus.mem_rdata;
  assign bus.rd_valid_m     = rd_valid_q;
  assign bus.drain_done     = drain_done_q && !rst;
  assign bus.fifo_count     = count_q;
  assign bus.err_misaligned = err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.ext_addr[DPW-1:2];
      fifo_data_q[wr_ptr_q] <= bus.ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      drain_done_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      drain_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.drain_req) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as this cycle's pop empties the FIFO, so a full
          // drain costs exactly FIFO_DEPTH DRAIN cycles.
          if (count_d == '0) begin
            state_q      <= DONE;
            drain_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int DPW   = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DPW(DPW), .FIFO_DEPTH(DEPTH)) bus ();

  dmem_arbiter #(.DPW(DPW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory attached to the arbiter
  bit [31:0] tb_mem [int];
  function automatic bit [31:0] rd_mem(input int a);
    return tb_mem.exists(a) ? tb_mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) tb_mem[int'(bus.mem_addr)] = bus.mem_wdata;
      else bus.mem_rdata <= rd_mem(int'(bus.mem_addr));
    end
  end

  // reference model: queue of pending writes, starvation count, mode
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  int          m_starve = 0;
  int          m_mode   = 0;   // 0 RUN, 1 DRAIN, 2 DONE
  bit          m_err    = 0;
  bit          m_rdv    = 0;
  bit          m_ready  = 0;
  logic [31:0] m_rd_exp = '0;
  bit [31:0]   model_mem [int];
  int          stall_seen = 0;
  int          done_seen  = 0;

  bit          preq, pw, fw, e_ready, e_stall, e_we;
  logic [29:0] e_addr;
  logic [31:0] e_wd;
  int          sz;

  always @(negedge clk) begin
    if (m_ready) begin
      check("fifo_count", bus.fifo_count, mq.size());
      check("err_misaligned", bus.err_misaligned, m_err);
      check("rd_valid_m", bus.rd_valid_m, m_rdv);
      if (m_rdv) check("readdata_m", bus.readdata_m, m_rd_exp);
      check("drain_done", bus.drain_done, !rst && m_mode == 2);
    end
    if (rst) begin
      check("rst_ext_ready", bus.ext_ready, 0);
      check("rst_stall", bus.stall_mem, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_drain_done", bus.drain_done, 0);
      mq.delete();
      m_starve = 0; m_mode = 0; m_err = 0; m_rdv = 0; m_ready = 1;
    end else if (m_ready) begin
      stall_seen += int'(bus.stall_mem);
      done_seen  += int'(bus.drain_done);
      preq = bus.memwriteM || bus.memreadM;
      sz   = mq.size();
      pw = 0; fw = 0;
      if (m_mode == 0) begin
        pw = preq && (m_starve < LIMIT);
        fw = !pw && (sz > 0);
      end else if (m_mode == 1) begin
        fw = sz > 0;
      end
      e_ready = (m_mode == 0) && (sz < DEPTH);
      e_stall = (m_mode != 0) || (fw && preq);
      e_we    = fw || (pw && bus.memwriteM);
      if (fw) begin
        e_addr = mq[0].a[31:2];
        e_wd   = mq[0].d;
      end else begin
        e_addr = bus.aluresultM[31:2];
        e_wd   = bus.Rd2M;
      end
      check("ext_ready", bus.ext_ready, e_ready);
      check("stall_mem", bus.stall_mem, e_stall);
      check("mem_en", bus.mem_en, pw || fw);
      if (pw || fw) begin
        check("mem_we", bus.mem_we, e_we);
        check("mem_addr", bus.mem_addr, e_addr);
        if (e_we) check("mem_wdata", bus.mem_wdata, e_wd);
      end
      if (e_we) model_mem[int'(e_addr)] = e_wd;
      m_rdv = pw && !bus.memwriteM;
      if (m_rdv) m_rd_exp = model_mem.exists(int'(e_addr)) ? model_mem[int'(e_addr)] : 32'h0;
      if (pw && bus.aluresultM[1:0] != 2'b00) m_err = 1;
      if (fw || sz == 0) m_starve = 0;
      else if (pw && m_starve < LIMIT) m_starve++;
      if (fw) void'(mq.pop_front());
      if (bus.ext_valid && e_ready) mq.push_back('{a: bus.ext_addr, d: bus.ext_data});
      case (m_mode)
        0: if (bus.drain_req) m_mode = 1;
        1: if (mq.size() == 0) m_mode = 2;
        default: m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int stall_at, acc5, done_at, n, pulses;
  bit stall_all, rdy_any;

  initial begin
    rst = 1'b1;
    bus.memwriteM = 0; bus.memreadM = 0; bus.aluresultM = '0; bus.Rd2M = '0;
    bus.ext_valid = 0; bus.ext_addr = '0; bus.ext_data = '0; bus.drain_req = 0;
    bus.mem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_reset_count", bus.fifo_count, 0);
    check("lit_reset_ready", bus.ext_ready, 1);
    check("lit_reset_rdv", bus.rd_valid_m, 0);
    check("lit_reset_err", bus.err_misaligned, 0);
    tick();

    // three preload writes with the pipeline idle
    stall_seen = 0;
    for (int i = 0; i < 3; i++) begin
      bus.ext_valid = 1;
      bus.ext_addr  = 32'h100 + 32'(4 * i);
      bus.ext_data  = 32'hA + 32'(i);
      tick();
    end
    bus.ext_valid = 0;
    repeat (2) tick();
    @(negedge clk);
    check("lit_t1_count", bus.fifo_count, 0);
    check("lit_t1_mem40", rd_mem(32'h40), 32'hA);
    check("lit_t1_mem41", rd_mem(32'h41), 32'hB);
    check("lit_t1_mem42", rd_mem(32'h42), 32'hC);
    check("lit_t1_nostall", stall_seen, 0);
    tick();

    // continuous loads with one pending write: forced slot after LIMIT wins
    bus.memreadM = 1; bus.aluresultM = 32'h100;
    bus.ext_valid = 1; bus.ext_addr = 32'h200; bus.ext_data = 32'h55;
    stall_at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.stall_mem && stall_at < 0) stall_at = k;
      tick();
      bus.ext_valid = 0;
    end
    check("lit_starve_slot", stall_at, 1 + LIMIT);
    check("lit_starve_mem80", rd_mem(32'h80), 32'h55);
    bus.memreadM = 0;

    // fill the FIFO while the pipeline stores continuously
    bus.memwriteM = 1; bus.aluresultM = 32'h300; bus.Rd2M = 32'h77;
    n = 0; acc5 = -1;
    for (int k = 0; k < 16; k++) begin
      bus.ext_valid = (n < 5);
      bus.ext_addr  = 32'h400 + 32'(4 * n);
      bus.ext_data  = 32'h1000 + 32'(n);
      @(negedge clk);
      if (k == 4) check("lit_full_ready", bus.ext_ready, 0);
      if (bus.ext_valid && bus.ext_ready) begin
        if (n == 4) acc5 = k;
        n++;
      end
      tick();
    end
    bus.ext_valid = 0;
    check("lit_full_accept", acc5, 10);

    // full drain with the pipeline requesting
    bus.drain_req = 1;
    done_at = -1; stall_all = 1; rdy_any = 0; pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.drain_done) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (k >= 1 && k <= 5) begin
        stall_all = stall_all && bus.stall_mem;
        rdy_any   = rdy_any || bus.ext_ready;
      end
      tick();
      bus.drain_req = 0;
    end
    check("lit_drain_done_at", done_at, 1 + DEPTH);
    check("lit_drain_pulses", pulses, 1);
    check("lit_drain_stall", stall_all, 1);
    check("lit_drain_ready", rdy_any, 0);
    check("lit_drain_mem104", rd_mem(32'h104), 32'h1004);
    bus.memwriteM = 0;

    // drain with an empty FIFO: one DRAIN cycle then DONE
    bus.drain_req = 1;
    done_at = -1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.drain_done && done_at < 0) done_at = k;
      tick();
      bus.drain_req = 0;
    end
    check("lit_empty_drain", done_at, 2);

    // misaligned store
    bus.memwriteM = 1; bus.aluresultM = 32'h0000_0102; bus.Rd2M = 32'h99;
    @(negedge clk);
    check("lit_mis_addr", bus.mem_addr, 30'h40);
    check("lit_mis_we", bus.mem_we, 1);
    tick();
    bus.memwriteM = 0;
    @(negedge clk);
    check("lit_mis_err", bus.err_misaligned, 1);
    repeat (3) tick();
    check("lit_mis_sticky", bus.err_misaligned, 1);

    // reset in the middle of a drain
    bus.memreadM = 1; bus.aluresultM = 32'h104;
    for (int k = 0; k < 3; k++) begin
      bus.ext_valid = 1;
      bus.ext_addr  = 32'h500 + 32'(4 * k);
      bus.ext_data  = 32'h2000 + 32'(k);
      tick();
    end
    bus.ext_valid = 0;
    bus.drain_req = 1;
    done_seen = 0;
    tick();
    bus.drain_req = 0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("lit_rst_pre_count", bus.fifo_count, 1);
    tick();
    @(negedge clk);
    check("lit_rst_count", bus.fifo_count, 0);
    check("lit_rst_err", bus.err_misaligned, 0);
    tick();
    rst = 1'b0;
    bus.memreadM = 0;
    repeat (4) tick();
    check("lit_rst_no_done", done_seen, 0);
    check("lit_rst_count_after", bus.fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
